// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one-cycle reads, latches the returned word,
// holds it for decode and computes the next PC on instruction retirement.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rddata,
  input  logic        mem_rdvalid,
  input  logic        mem_sel,
  input  logic [1:0]  PCSrc,
  input  logic        br_taken,
  input  logic [15:0] rind_addr,
  input  logic        instr_done,
  output logic [15:0] instr,
  output logic [4:0]  opcode,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DECODE
  } state_t;

  localparam logic [3:0] TIMEOUT_LAST = 4'(RD_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [15:0] pc_r;
  logic [15:0] pc_nxt;
  logic [15:0] br_off;
  logic        issue;
  logic        accept;
  logic        timeout;
  logic        retire;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (!mem_sel) state_nxt = WAIT;
      WAIT: begin
        if (mem_rdvalid)  state_nxt = DECODE;
        else if (timeout) state_nxt = FETCH;
      end
      DECODE:  if (instr_done) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // State-decoded strobes and next-PC selection
  always_comb begin
    issue   = (state == FETCH) && !mem_sel;
    accept  = (state == WAIT) && mem_rdvalid;
    timeout = (state == WAIT) && !mem_rdvalid && (wait_cnt == TIMEOUT_LAST);
    retire  = (state == DECODE) && instr_done;
    br_off  = {{4{instr[15]}}, instr[15:5], 1'b0};
    pc_nxt  = pc_plus2;
    case (PCSrc)
      2'b00:   if (br_taken) pc_nxt = pc_plus2 + br_off;
      2'b01:   pc_nxt = {rind_addr[15:1], 1'b0};
      default: pc_nxt = pc_plus2;
    endcase
  end

  // The read strobe is registered, so it is seen during the first WAIT cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_r        <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= RESET_PC;
      retired     <= '0;
      wait_cnt    <= '0;
    end else begin
      mem_rd <= issue;
      if (issue) begin
        mem_addr <= pc_r;
        wait_cnt <= '0;
      end else if ((state == WAIT) && !mem_rdvalid) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (accept) begin
        instr       <= mem_rddata;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        pc_r        <= pc_nxt;
        retired     <= retired + 16'd1;
        instr_valid <= 1'b0;
      end
    end
  end

  assign pc       = pc_r;
  assign pc_plus2 = pc_r + 16'd2;
  assign opcode   = instr[4:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: read handshake, PC selection, timeout,
// ignored strobes and reset abort.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rddata;
  logic        mem_rdvalid;
  logic        mem_sel;
  logic [1:0]  PCSrc;
  logic        br_taken;
  logic [15:0] rind_addr;
  logic        instr_done;
  logic [15:0] instr;
  logic [4:0]  opcode;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [15:0] retired;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  fetch_unit #(.RESET_PC(16'h0000), .RD_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rddata(mem_rddata), .mem_rdvalid(mem_rdvalid), .mem_sel(mem_sel),
    .PCSrc(PCSrc), .br_taken(br_taken), .rind_addr(rind_addr),
    .instr_done(instr_done), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc), .pc_plus2(pc_plus2), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bounded wait for the next read strobe, sampled on falling edges
  task automatic wait_rd(output logic [15:0] addr, output int unsigned at);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL wait_rd: mem_rd not seen within 40 cycles, required a read");
    else n_pass++;
    addr = mem_addr;
    at   = cyc;
  endtask

  // Return data the cycle after mem_rd; leaves the DUT in DECODE
  task automatic reply(input logic [15:0] data);
    @(negedge clk);
    mem_rdvalid = 1'b1;
    mem_rddata  = data;
    @(negedge clk);
    mem_rdvalid = 1'b0;
    mem_rddata  = 16'h0000;
  endtask

  task automatic finish_instr(input logic [1:0] src, input logic br, input logic [15:0] ra);
    PCSrc      = src;
    br_taken   = br;
    rind_addr  = ra;
    instr_done = 1'b1;
    @(negedge clk);
    instr_done = 1'b0;
    PCSrc      = 2'b10;
    br_taken   = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h required 0000", pc); else n_pass++;
    n_checks++; if (instr !== 16'h0000) $display("FAIL reset_instr: got %h required 0000", instr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", instr_valid); else n_pass++;
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b required 0", mem_rd); else n_pass++;
    n_checks++; if (retired !== 16'h0000) $display("FAIL reset_retired: got %h required 0000", retired); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] a;
    int unsigned t0, t1;
    wait_rd(a, t0);
    n_checks++; if (a !== 16'h0000) $display("FAIL basic_addr: got %h required 0000", a); else n_pass++;
    reply(16'h0021);
    n_checks++; if (instr !== 16'h0021) $display("FAIL basic_instr: got %h required 0021", instr); else n_pass++;
    n_checks++; if (opcode !== 5'b00001) $display("FAIL basic_opcode: got %b required 00001", opcode); else n_pass++;
    n_checks++; if (instr_valid !== 1'b1) $display("FAIL basic_valid: got %b required 1", instr_valid); else n_pass++;
    n_checks++; if (pc_plus2 !== 16'h0002) $display("FAIL basic_pc_plus2: got %h required 0002", pc_plus2); else n_pass++;
    finish_instr(2'b10, 1'b0, 16'h0000);
    n_checks++; if (pc !== 16'h0002) $display("FAIL basic_next_pc: got %h required 0002", pc); else n_pass++;
    n_checks++; if (retired !== 16'h0001) $display("FAIL basic_retired: got %h required 0001", retired); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b required 0", instr_valid); else n_pass++;
    wait_rd(a, t1);
    n_checks++; if (a !== 16'h0002) $display("FAIL basic_fetch2_addr: got %h required 0002", a); else n_pass++;
    n_checks++; if (t1 - t0 != 4) $display("FAIL basic_period: got %0d cycles required 4", t1 - t0); else n_pass++;
    reply(16'h0005);
    finish_instr(2'b01, 1'b0, 16'h0011);
    n_checks++; if (pc !== 16'h0010) $display("FAIL basic_rind_odd: got %h required 0010", pc); else n_pass++;
  endtask

  task automatic test_branch;
    logic [15:0] a;
    int unsigned t;
    wait_rd(a, t);
    n_checks++; if (a !== 16'h0010) $display("FAIL br_addr: got %h required 0010", a); else n_pass++;
    reply(16'hFFD8);
    n_checks++; if (opcode !== 5'b11000) $display("FAIL br_opcode: got %b required 11000", opcode); else n_pass++;
    finish_instr(2'b00, 1'b1, 16'h0000);
    n_checks++; if (pc !== 16'h000E) $display("FAIL br_taken: got %h required 000E", pc); else n_pass++;
    wait_rd(a, t);
    reply(16'h0000);
    finish_instr(2'b10, 1'b0, 16'h0000);
    n_checks++; if (pc !== 16'h0010) $display("FAIL br_seq: got %h required 0010", pc); else n_pass++;
    wait_rd(a, t);
    reply(16'hFFD8);
    finish_instr(2'b00, 1'b0, 16'h0000);
    n_checks++; if (pc !== 16'h0012) $display("FAIL br_not_taken: got %h required 0012", pc); else n_pass++;
  endtask

  task automatic test_rind_wrap;
    logic [15:0] a;
    int unsigned t;
    wait_rd(a, t);
    reply(16'h0003);
    finish_instr(2'b01, 1'b0, 16'h1235);
    n_checks++; if (pc !== 16'h1234) $display("FAIL rind_pc: got %h required 1234", pc); else n_pass++;
    wait_rd(a, t);
    n_checks++; if (a !== 16'h1234) $display("FAIL rind_addr: got %h required 1234", a); else n_pass++;
    reply(16'h0003);
    finish_instr(2'b01, 1'b0, 16'hFFFF);
    wait_rd(a, t);
    n_checks++; if (a !== 16'hFFFE) $display("FAIL wrap_addr: got %h required FFFE", a); else n_pass++;
    reply(16'h0007);
    n_checks++; if (pc_plus2 !== 16'h0000) $display("FAIL wrap_pc_plus2: got %h required 0000", pc_plus2); else n_pass++;
    finish_instr(2'b11, 1'b1, 16'h5555);
    n_checks++; if (pc !== 16'h0000) $display("FAIL wrap_pc: got %h required 0000", pc); else n_pass++;
    n_checks++; if (retired !== 16'h0008) $display("FAIL rind_retired: got %h required 0008", retired); else n_pass++;
  endtask

  task automatic test_ignore;
    mem_sel     = 1'b1;
    instr_done  = 1'b1;
    mem_rdvalid = 1'b1;
    mem_rddata  = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (mem_rd !== 1'b0) $display("FAIL sel_no_rd[%0d]: got %b required 0", i, mem_rd); else n_pass++;
    end
    n_checks++; if (retired !== 16'h0008) $display("FAIL done_ignored: got %h required 0008", retired); else n_pass++;
    n_checks++; if (instr !== 16'h0007) $display("FAIL rdvalid_ignored: got %h required 0007", instr); else n_pass++;
    n_checks++; if (pc !== 16'h0000) $display("FAIL sel_pc: got %h required 0000", pc); else n_pass++;
    mem_sel     = 1'b0;
    instr_done  = 1'b0;
    mem_rdvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b1) $display("FAIL sel_release_rd: got %b required 1", mem_rd); else n_pass++;
    reply(16'h0042);
    mem_sel     = 1'b1;
    mem_rdvalid = 1'b1;
    mem_rddata  = 16'hAAAA;
    repeat (2) @(negedge clk);
    mem_sel     = 1'b0;
    mem_rdvalid = 1'b0;
    n_checks++; if (instr_valid !== 1'b1) $display("FAIL decode_sel_valid: got %b required 1", instr_valid); else n_pass++;
    n_checks++; if (instr !== 16'h0042) $display("FAIL decode_rdvalid: got %h required 0042", instr); else n_pass++;
    finish_instr(2'b10, 1'b0, 16'h0000);
    n_checks++; if (pc !== 16'h0002) $display("FAIL ignore_next_pc: got %h required 0002", pc); else n_pass++;
  endtask

  task automatic test_timeout;
    logic [15:0] a1, a2;
    int unsigned t1, t2;
    wait_rd(a1, t1);
    wait_rd(a2, t2);
    n_checks++; if (a2 !== 16'h0002) $display("FAIL to_reissue_addr: got %h required 0002", a2); else n_pass++;
    n_checks++; if (t2 - t1 != 16) $display("FAIL to_gap: got %0d cycles required 16", t2 - t1); else n_pass++;
    reply(16'h0123);
    n_checks++; if (instr !== 16'h0123) $display("FAIL to_accept: got %h required 0123", instr); else n_pass++;
    finish_instr(2'b10, 1'b0, 16'h0000);
    n_checks++; if (pc !== 16'h0004) $display("FAIL to_next_pc: got %h required 0004", pc); else n_pass++;
  endtask

  task automatic test_reset_abort;
    logic [15:0] a;
    int unsigned t;
    wait_rd(a, t);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (mem_addr !== 16'h0000) $display("FAIL abort_mem_addr: got %h required 0000", mem_addr); else n_pass++;
    n_checks++; if (pc !== 16'h0000) $display("FAIL abort_pc: got %h required 0000", pc); else n_pass++;
    n_checks++; if (retired !== 16'h0000) $display("FAIL abort_retired: got %h required 0000", retired); else n_pass++;
    reset_n     = 1'b1;
    mem_rdvalid = 1'b1;
    mem_rddata  = 16'hBEEF;
    @(negedge clk);
    mem_rdvalid = 1'b0;
    n_checks++; if (instr !== 16'h0000) $display("FAIL abort_late_data: got %h required 0000", instr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL abort_valid: got %b required 0", instr_valid); else n_pass++;
    n_checks++; if (mem_rd !== 1'b1) $display("FAIL abort_fresh_rd: got %b required 1", mem_rd); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0000) $display("FAIL abort_fresh_addr: got %h required 0000", mem_addr); else n_pass++;
    reply(16'h0021);
    n_checks++; if (instr !== 16'h0021) $display("FAIL abort_resume: got %h required 0021", instr); else n_pass++;
  endtask

  initial begin
    reset_n     = 1'b0;
    mem_rddata  = 16'h0000;
    mem_rdvalid = 1'b0;
    mem_sel     = 1'b0;
    PCSrc       = 2'b10;
    br_taken    = 1'b0;
    rind_addr   = 16'h0000;
    instr_done  = 1'b0;
    test_reset();
    test_basic();
    test_branch();
    test_rind_wrap();
    test_ignore();
    test_timeout();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
